// File: rtl/mips_fwd_pkg.sv
// Shared encodings and tag-entry type for the EX-stage forwarding network.
// The EX operand muxes decode the same FWD_* values.
package mips_fwd_pkg;

  localparam logic [1:0] FWD_GPR  = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM1 = 2'b10;
  localparam logic [1:0] FWD_MEM2 = 2'b11;

  // Tags are sized for the 32-entry integer register file.
  localparam int GPR_AW = 5;

  typedef struct packed {
    logic              v;
    logic [GPR_AW-1:0] dst;
    logic              late;
  } tag_t;

  localparam tag_t TAG_EMPTY = '{v: 1'b0, dst: '0, late: 1'b0};

endpackage

// File: rtl/fwd_src_resolve.sv
// Resolves one source operand against the in-flight destination tags:
// youngest match wins, late producers not yet finished raise a hazard.
module fwd_src_resolve
  import mips_fwd_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  tag_t              ex_tag,
  input  tag_t              mem1_tag,
  input  tag_t              mem2_tag,
  input  tag_t              wb_tag,
  output logic [1:0]        sel,
  output logic              hazard
);

  function automatic logic hit(input tag_t t);
    return used && (src != '0) && t.v && (t.dst == src);
  endfunction

  // NOTE: every output gets a default before the priority chain so no latch is inferred.
  always_comb begin
    sel    = FWD_GPR;
    hazard = 1'b0;
    if (hit(ex_tag)) begin
      if (ex_tag.late) hazard = 1'b1;
      else             sel    = FWD_MEM1;
    end else if (hit(mem1_tag)) begin
      if (mem1_tag.late) hazard = 1'b1;
      else               sel    = FWD_MEM2;
    end else if (hit(mem2_tag)) begin
      sel = FWD_WB;
    end else if (hit(wb_tag)) begin
      // Write-first register file: the GPR read already sees this result.
      sel = FWD_GPR;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller for the 5-stage pipeline.
// Keeps a shadow pipeline of destination tags advanced like ID/EX.
module fwd_hazard_ctrl
  import mips_fwd_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_late,
  input  logic              stall_ext,
  input  logic              flush,
  output logic              stall_id,
  output logic [1:0]        ex_fwd_a,
  output logic [1:0]        ex_fwd_b
);

  tag_t ex_tag, mem1_tag, mem2_tag, wb_tag;
  tag_t id_tag;

  logic [1:0] sel_a, sel_b;
  logic       haz_a, haz_b;

  fwd_src_resolve #(.REG_AW(REG_AW)) u_rs (
    .src      (id_rs),
    .used     (id_rs_used),
    .ex_tag   (ex_tag),
    .mem1_tag (mem1_tag),
    .mem2_tag (mem2_tag),
    .wb_tag   (wb_tag),
    .sel      (sel_a),
    .hazard   (haz_a)
  );

  fwd_src_resolve #(.REG_AW(REG_AW)) u_rt (
    .src      (id_rt),
    .used     (id_rt_used),
    .ex_tag   (ex_tag),
    .mem1_tag (mem1_tag),
    .mem2_tag (mem2_tag),
    .wb_tag   (wb_tag),
    .sel      (sel_b),
    .hazard   (haz_b)
  );

  assign stall_id = id_valid && (haz_a || haz_b) && !flush;

  // Writes to $0 never produce a forwardable result.
  assign id_tag = '{v:    id_valid && id_wr_en && (id_dst != '0),
                    dst:  id_dst,
                    late: id_late};

  // NOTE: state uses non-blocking assignments and an async active-low reset;
  // the tag shift relies on every register sampling its old neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_tag   <= TAG_EMPTY;
      mem1_tag <= TAG_EMPTY;
      mem2_tag <= TAG_EMPTY;
      wb_tag   <= TAG_EMPTY;
      ex_fwd_a <= FWD_GPR;
      ex_fwd_b <= FWD_GPR;
    end else if (!stall_ext) begin
      wb_tag   <= mem2_tag;
      mem2_tag <= mem1_tag;
      mem1_tag <= flush ? TAG_EMPTY : ex_tag;
      if (stall_id || flush) begin
        ex_tag   <= TAG_EMPTY;
        ex_fwd_a <= FWD_GPR;
        ex_fwd_b <= FWD_GPR;
      end else begin
        ex_tag   <= id_tag;
        ex_fwd_a <= id_valid ? sel_a : FWD_GPR;
        ex_fwd_b <= id_valid ? sel_b : FWD_GPR;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: a per-cycle vector table plus
// hand-written freeze and asynchronous-reset sequences.
module tb_fwd_hazard_ctrl;

  typedef struct {
    logic       valid;
    logic [4:0] rs;
    logic       rs_used;
    logic [4:0] rt;
    logic       rt_used;
    logic       wr_en;
    logic [4:0] dst;
    logic       late;
    logic       ext;
    logic       flush;
    logic       exp_stall;
    logic [1:0] exp_a;
    logic [1:0] exp_b;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs_used, id_rt_used, id_wr_en, id_late;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       stall_ext, flush;
  logic       stall_id;
  logic [1:0] ex_fwd_a, ex_fwd_b;

  int checks   = 0;
  int failures = 0;

  fwd_hazard_ctrl #(.REG_AW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .id_wr_en   (id_wr_en),
    .id_dst     (id_dst),
    .id_late    (id_late),
    .stall_ext  (stall_ext),
    .flush      (flush),
    .stall_id   (stall_id),
    .ex_fwd_a   (ex_fwd_a),
    .ex_fwd_b   (ex_fwd_b)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic valid, input logic [4:0] rs, input logic rs_used,
                              input logic [4:0] rt, input logic rt_used, input logic wr_en,
                              input logic [4:0] dst, input logic late, input logic ext,
                              input logic flush_i, input logic exp_stall,
                              input logic [1:0] exp_a, input logic [1:0] exp_b);
    vec_t v;
    v.valid = valid;  v.rs = rs;  v.rs_used = rs_used;  v.rt = rt;  v.rt_used = rt_used;
    v.wr_en = wr_en;  v.dst = dst;  v.late = late;  v.ext = ext;  v.flush = flush_i;
    v.exp_stall = exp_stall;  v.exp_a = exp_a;  v.exp_b = exp_b;
    return v;
  endfunction

  function automatic vec_t nop(input logic ext, input logic [1:0] exp_a, input logic [1:0] exp_b);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, ext, 0, 0, exp_a, exp_b);
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    id_valid   = v.valid;  id_rs = v.rs;  id_rs_used = v.rs_used;
    id_rt      = v.rt;     id_rt_used = v.rt_used;
    id_wr_en   = v.wr_en;  id_dst = v.dst;  id_late = v.late;
    stall_ext  = v.ext;    flush = v.flush;
  endtask

  // Drive one ID cycle, sample mid-cycle, then advance past the next edge.
  task automatic step(input vec_t v, input string name);
    apply(v);
    @(negedge clk);
    check({name, ".stall_id"}, {1'b0, stall_id}, {1'b0, v.exp_stall});
    check({name, ".fwd_a"}, ex_fwd_a, v.exp_a);
    check({name, ".fwd_b"}, ex_fwd_b, v.exp_b);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t ldu;

  initial begin
    rst_n = 1'b0;
    apply(nop(0, 0, 0));
    #3;
    check("reset.stall_id", {1'b0, stall_id}, 2'b00);
    check("reset.fwd_a", ex_fwd_a, 2'b00);
    check("reset.fwd_b", ex_fwd_b, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // valid rs rsu rt rtu wr dst late ext flush | stall a b (a/b = current EX selects)
    // early producer back-to-back
    tbl.push_back(mk(1, 1, 1, 2, 1, 1, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 1, 3, 1, 1, 5, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 2, 2));
    // load-use with adjacent producer: two stalls, then WB forward
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4, 1, 4, 1, 1, 7, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4, 1, 4, 1, 1, 7, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 4, 1, 4, 1, 1, 7, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 1, 1));
    // late write to $0, then a reader of $0
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0));
    // addu $5, ori $5, reader: younger wins, then MEM2 forward two cycles on
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 2, 0));
    tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 1, 0));
    // early producer two ahead: forward from MEM1 result (select 11)
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 3));
    // late producer one instruction ahead: one stall
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0));
    tbl.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 1, 0));
    // flush kills the $6 producer in EX; reader sees no forward
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // Load-use interrupted by a 3-cycle freeze: still exactly 2 live stall cycles.
    ldu = mk(1, 10, 1, 10, 1, 1, 11, 0, 0, 0, 1, 0, 0);
    step(mk(1, 1, 1, 0, 0, 1, 10, 1, 0, 0, 0, 0, 0), "frz.lw");
    step(ldu, "frz.use0");
    ldu.ext = 1'b1;
    for (int i = 0; i < 3; i++) step(ldu, $sformatf("frz.hold%0d", i));
    ldu.ext = 1'b0;
    step(ldu, "frz.use1");
    ldu.exp_stall = 1'b0;
    step(ldu, "frz.go");
    step(nop(1, 1, 1), "frz.sel0");
    step(nop(1, 1, 1), "frz.sel1");
    step(nop(0, 1, 1), "frz.sel2");
    step(nop(0, 0, 0), "frz.sel3");

    // Async reset mid-cycle while a stall and a live forward are present.
    step(mk(1, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 0), "rst.p12");
    step(mk(1, 12, 1, 0, 0, 1, 13, 1, 0, 0, 0, 0, 0), "rst.lw13");
    apply(mk(1, 13, 1, 0, 0, 1, 14, 0, 0, 0, 1, 2, 0));
    @(negedge clk);
    check("rst.pre.stall_id", {1'b0, stall_id}, 2'b01);
    check("rst.pre.fwd_a", ex_fwd_a, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.async.stall_id", {1'b0, stall_id}, 2'b00);
    check("rst.async.fwd_a", ex_fwd_a, 2'b00);
    check("rst.async.fwd_b", ex_fwd_b, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(mk(1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst.after");
    step(nop(0, 0, 0), "rst.after2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
